// File: rtl/aes_pkg.sv
// Shared AES definitions: block geometry, byte ordering helper, SubBytes FSM states.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package aes_pkg;

  localparam int AES_BLOCK_W = 128;
  localparam int AES_BYTE_W  = 8;
  localparam int AES_NBYTES  = 16;

  // Packed view of a 128-bit block: element [15] is the MSB byte, i.e. FIPS-197 byte 0.
  typedef logic [AES_NBYTES-1:0][AES_BYTE_W-1:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sb_state_t;

  // Map a FIPS-197 byte index (0 = MSB byte) to its slot in aes_state_t.
  function automatic logic [3:0] byte_slot(input logic [3:0] idx);
    return 4'(AES_NBYTES - 1) - idx;
  endfunction

endpackage

// File: rtl/sbox_fwd.sv
// Forward AES S-box, one byte in, one byte out, pure lookup.
// Latency: combinational.
// Backpressure: none.
module sbox_fwd
  import aes_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] in_byte,
  output logic [AES_BYTE_W-1:0] out_byte
);

  // Row r holds S(16r) .. S(16r+15); S(00) sits in the top byte of the vector.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry x lives at bit offset 8*(255-x); 255-x is simply ~x for an 8-bit x.
  assign out_byte = SBOX_TABLE[{~in_byte, 3'b000} +: AES_BYTE_W];

endmodule

// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes: LANES bytes per cycle through time-shared forward S-boxes.
// Latency: 16/LANES cycles from input handshake to out_valid; one block per 16/LANES+2 cycles.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready; flush aborts anywhere.
module sub_bytes_seq
  import aes_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [AES_BLOCK_W-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [AES_BLOCK_W-1:0] out_state,
  input  logic                   flush,
  output logic                   busy
);

  localparam int NCHUNK = AES_NBYTES / LANES;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
      $error("sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  sb_state_t            state_q, state_d;
  aes_state_t           buf_q, buf_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  logic [3:0]           chunk_base;
  logic [3:0]           lane_slot [LANES];
  logic [AES_BYTE_W-1:0] sbox_in  [LANES];
  logic [AES_BYTE_W-1:0] sbox_out [LANES];

  // Pick the bytes of the current chunk out of the buffer, one per lane.
  always_comb begin
    chunk_base = 4'(int'(cnt_q) * LANES);
    for (int l = 0; l < LANES; l++) begin
      lane_slot[l] = byte_slot(chunk_base + 4'(l));
      sbox_in[l]   = buf_q[lane_slot[l]];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sbox_fwd u_sbox (
      .in_byte  (sbox_in[g]),
      .out_byte (sbox_out[g])
    );
  end

  // Next-state, in-place substitution and handshake outputs; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    buf_d     = buf_q;
    cnt_d     = cnt_q;
    // Both handshake signals are masked by flush so no transfer can complete in an aborted cycle.
    in_ready  = (state_q == IDLE) && !flush;
    out_valid = (state_q == DONE) && !flush;
    busy      = (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          buf_d   = in_state;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        for (int l = 0; l < LANES; l++) begin
          buf_d[lane_slot[l]] = sbox_out[l];
        end
        if (cnt_q == CNT_W'(NCHUNK - 1)) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
      buf_d   = buf_q;
    end
  end

  // State, buffer and chunk counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      buf_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_state = buf_q;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Directed and randomized checks of sub_bytes_seq at LANES = 4, 1, 16, 2, 8.
// Latency: n/a.
// Backpressure: n/a.
module tb_sub_bytes_seq;

  localparam int NDUT = 5;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [NDUT];
  logic         in_ready  [NDUT];
  logic [127:0] in_state  [NDUT];
  logic         out_valid [NDUT];
  logic         out_ready [NDUT];
  logic [127:0] out_state [NDUT];
  logic         flush     [NDUT];
  logic         busy      [NDUT];

  int n_chk = 0;
  int n_bad = 0;

  logic [7:0] inv_tbl [256];

  always #5 clk = ~clk;

  // Instance 0: LANES=4, 1: LANES=1, 2: LANES=16, 3: LANES=2, 4: LANES=8.
  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    localparam int LN = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 16 : (g == 3) ? 2 : 8;
    sub_bytes_seq #(.LANES(LN)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_state  (in_state[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_state (out_state[g]),
      .flush     (flush[g]),
      .busy      (busy[g])
    );
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference S-box built from GF(2^8) arithmetic, used only to derive the inverse table.
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xt(x);
      y = {1'b0, y[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] ref_sbox(input logic [7:0] a);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, a);
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] inv_state(input logic [127:0] s);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = inv_tbl[s[8*i +: 8]];
    return r;
  endfunction

  // Present a block at a negedge, wait for in_ready, return just after the accepting edge.
  task automatic accept(input int k, input logic [127:0] st);
    int w = 0;
    in_valid[k] = 1'b1;
    in_state[k] = st;
    #1;
    while (!in_ready[k] && w < 50) begin
      @(negedge clk); #1;
      w++;
    end
    chk("acc_wait", 128'(w < 50), 128'd1);
    @(negedge clk);
    in_valid[k] = 1'b0;
    #1;
  endtask

  // Count clock edges after acceptance until out_valid is seen.
  task automatic wait_out(input int k, output int n);
    n = 0;
    while (!out_valid[k] && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
  endtask

  task automatic sweep(input int k, input int nblk);
    logic [127:0] q[$];
    logic [127:0] exp;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    bit acc = 1'b0;
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b0;
    while ((sent < nblk || got < nblk) && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (acc) begin
        in_valid[k] = 1'b0;
        acc = 1'b0;
      end
      if (!in_valid[k] && sent < nblk && $urandom_range(9) < 7) begin
        in_valid[k] = 1'b1;
        in_state[k] = {$urandom, $urandom, $urandom, $urandom};
      end
      out_ready[k] = ($urandom_range(9) < 7);
      #1;
      chk("rdy_busy", 128'(in_ready[k] & busy[k]), 128'd0);
      if (in_valid[k] && in_ready[k]) begin
        q.push_back(in_state[k]);
        sent++;
        acc = 1'b1;
      end
      if (out_valid[k] && out_ready[k]) begin
        if (q.size() == 0) begin
          chk("sweep_dup", 128'd1, 128'd0);
        end else begin
          exp = q.pop_front();
          chk("sweep_blk", inv_state(out_state[k]), exp);
        end
        got++;
      end
    end
    in_valid[k] = 1'b0;
    out_ready[k] = 1'b0;
    chk("sweep_cnt", 128'(got), 128'(nblk));
    chk("sweep_left", 128'(q.size()), 128'd0);
  endtask

  initial begin
    int n;
    bit seen;

    for (int x = 0; x < 256; x++) inv_tbl[ref_sbox(8'(x))] = 8'(x);

    rst_n = 1'b0;
    for (int k = 0; k < NDUT; k++) begin
      in_valid[k] = 1'b0;
      in_state[k] = '0;
      out_ready[k] = 1'b0;
      flush[k] = 1'b0;
    end
    repeat (3) @(negedge clk);
    #1;
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_in_ready", 128'(in_ready[k]), 128'd1);
      chk("rst_out_valid", 128'(out_valid[k]), 128'd0);
    end
    chk("rst_busy", 128'(busy[0]), 128'd0);
    chk("rst_out_state", out_state[0], 128'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Reset asserted in the middle of RUN.
    @(negedge clk);
    accept(0, 128'h00112233445566778899aabbccddeeff);
    @(negedge clk); #1;
    chk("t1_busy_before", 128'(busy[0]), 128'd1);
    rst_n = 1'b0;
    #1;
    chk("t1_out_valid", 128'(out_valid[0]), 128'd0);
    chk("t1_busy", 128'(busy[0]), 128'd0);
    chk("t1_in_ready", 128'(in_ready[0]), 128'd1);
    chk("t1_out_state", out_state[0], 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // LANES=4, all-zero block, consumer always ready.
    out_ready[0] = 1'b1;
    accept(0, 128'h0);
    chk("t2_busy", 128'(busy[0]), 128'd1);
    wait_out(0, n);
    chk("t2_latency", 128'(n), 128'd4);
    chk("t2_out_state", out_state[0], 128'h63636363636363636363636363636363);
    chk("t2_in_ready_done", 128'(in_ready[0]), 128'd0);
    @(negedge clk); #1;
    chk("t2_out_valid_after", 128'(out_valid[0]), 128'd0);
    chk("t2_in_ready_after", 128'(in_ready[0]), 128'd1);

    // LANES=1, FIPS-197 style ramp.
    out_ready[1] = 1'b1;
    accept(1, 128'h00102030405060708090a0b0c0d0e0f0);
    wait_out(1, n);
    chk("t3_latency", 128'(n), 128'd16);
    chk("t3_out_state", out_state[1], 128'h63cab7040953d051cd60e0e7ba70e18c);
    @(negedge clk);

    // LANES=16, single cycle, result held under backpressure.
    out_ready[2] = 1'b0;
    accept(2, 128'h0153ff00000000000000000000000000);
    wait_out(2, n);
    chk("t4_latency", 128'(n), 128'd1);
    for (int c = 0; c < 5; c++) begin
      chk("t4_hold_valid", 128'(out_valid[2]), 128'd1);
      chk("t4_hold_state", out_state[2], 128'h7ced1663636363636363636363636363);
      @(negedge clk); #1;
    end
    out_ready[2] = 1'b1;
    @(negedge clk); #1;
    chk("t4_released", 128'(out_valid[2]), 128'd0);
    out_ready[2] = 1'b0;

    // Flush during the second RUN cycle at LANES=4.
    out_ready[0] = 1'b1;
    accept(0, 128'hffeeddccbbaa99887766554433221100);
    @(negedge clk);
    flush[0] = 1'b1;
    #1;
    chk("t5_busy_pre", 128'(busy[0]), 128'd1);
    @(negedge clk);
    flush[0] = 1'b0;
    #1;
    chk("t5_busy_post", 128'(busy[0]), 128'd0);
    chk("t5_in_ready_post", 128'(in_ready[0]), 128'd1);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      seen = seen | out_valid[0];
      @(negedge clk); #1;
    end
    chk("t5_no_out_valid", 128'(seen), 128'd0);

    // Flush together with in_valid in IDLE: nothing is taken.
    flush[0] = 1'b1;
    in_valid[0] = 1'b1;
    in_state[0] = 128'h0123456789abcdef0123456789abcdef;
    #1;
    chk("t5_flush_in_ready", 128'(in_ready[0]), 128'd0);
    @(negedge clk);
    flush[0] = 1'b0;
    in_valid[0] = 1'b0;
    #1;
    chk("t5_flush_no_accept", 128'(busy[0]), 128'd0);

    // A fresh block after the flush, then flush racing out_ready in DONE.
    out_ready[0] = 1'b0;
    accept(0, 128'h00102030405060708090a0b0c0d0e0f0);
    wait_out(0, n);
    chk("t5_latency", 128'(n), 128'd4);
    chk("t5_out_state", out_state[0], 128'h63cab7040953d051cd60e0e7ba70e18c);
    out_ready[0] = 1'b1;
    flush[0] = 1'b1;
    #1;
    chk("t5_done_flush_valid", 128'(out_valid[0]), 128'd0);
    @(negedge clk);
    flush[0] = 1'b0;
    #1;
    chk("t5_done_flush_busy", 128'(busy[0]), 128'd0);
    chk("t5_done_flush_out", 128'(out_valid[0]), 128'd0);
    out_ready[0] = 1'b0;
    @(negedge clk);

    // Randomized traffic with stalls on every lane configuration.
    fork
      sweep(0, 1000);
      sweep(1, 1000);
      sweep(2, 1000);
      sweep(3, 1000);
      sweep(4, 1000);
    join

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/sub_bytes_seq.md
Name: sub_bytes_seq

Overview:
Iterative AES forward SubBytes engine for the encryption datapath. It accepts a 128-bit AES state over a valid/ready handshake and substitutes LANES bytes per cycle through forward S-box instances. It returns the substituted state over a second valid/ready handshake. It is the encrypt-side counterpart of the inverse S-box used by decryption, and trades latency for area by time-sharing the S-box instances.

Parameters:
LANES, 4, number of bytes substituted per cycle; legal values are 1, 2, 4, 8, 16; any other value is an elaboration error.
NCHUNK, 16/LANES, derived localparam giving the number of RUN cycles per block.

Ports:
clk  input  1  single clock, rising edge.
rst_n  input  1  reset, asynchronous and active-low.
in_valid  input  1  in_state is valid.
in_ready  output  1  engine can accept a block; high only in IDLE.
in_state  input  128  input state; byte i = in_state[127-8*i -: 8], so byte 0 is the MSB byte (FIPS-197 column-major order).
out_valid  output  1  out_state holds a finished block.
out_ready  input  1  consumer accepts out_state.
out_state  output  128  substituted state, same byte order as in_state.
flush  input  1  synchronous abort; the current block is discarded.
busy  output  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - state = IDLE; buffer = 0; cnt = 0.
  - out_valid = 0, out_state = 0, busy = 0, in_ready = 1.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: buffer <= in_state; cnt <= 0; go to RUN.
- RUN:
  - Each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 of buffer are replaced in place with S(byte).
  - cnt increments by 1.
  - When cnt == NCHUNK-1, the last chunk is written and the next state is DONE.
  - in_ready = 0.
- DONE:
  - out_valid = 1; out_state = buffer, held stable while out_ready = 0.
  - On out_ready, go to IDLE next cycle. There is no same-cycle acceptance of a new block (in_ready is low in DONE).
- Latency:
  - Acceptance at edge T gives out_valid high after edge T+NCHUNK.
  - LANES=4: 4 cycles. LANES=1: 16 cycles. LANES=16: 1 cycle.
- Throughput: one block per NCHUNK+2 cycles, given out_ready is held high.
- out_state is registered (buffer). Bytes not yet processed hold the input values; out_state is only meaningful while out_valid is high.
- S-box: the standard FIPS-197 forward table, S(x) = affine(x^-1) with S(00)=63. It is combinational; LANES instances sit on a per-lane mux from buffer.
- cnt width is clog2(NCHUNK), minimum 1 bit. It never wraps inside a block; it is reset to 0 on accept.
- flush:
  - Highest priority in every state: next state IDLE, out_valid = 0, cnt = 0. buffer is left unchanged.
  - flush together with in_valid in IDLE: the block is not accepted, so in_ready is gated low while flush is high.
- out_ready and flush together in DONE: flush wins; the block counts as not delivered.
- in_valid held high while busy is ignored. The producer must hold in_state until in_ready.
- Reset mid-RUN or mid-DONE: immediate return to reset values; the partial block is lost.

Decomposition:
- Shared package aes_pkg:
  - AES_BLOCK_W = 128, AES_BYTE_W = 8, AES_NBYTES = 16.
  - byte-index helper function for the MSB-first ordering.
  - FSM state typedef sb_state_t {IDLE, RUN, DONE}.
- Sub-module sbox_fwd: 8-bit in to 8-bit out, a 256-entry combinational forward table. It is instantiated LANES times and reused by key expansion.

Test Plan:
1. Reset with rst_n=0 mid-RUN for LANES=4 -> in the same cycle out_valid=0, busy=0, in_ready=1, out_state=128'h0.
2. LANES=4, in_state=128'h0 accepted at edge T, out_ready=1 -> out_valid rises after edge T+4, out_state=128'h636363...63, in_ready returns high the cycle after handshake.
3. LANES=1, in_state=128'h00102030405060708090a0b0c0d0e0f0 -> after 16 RUN cycles out_state=128'h63cab7040953d051cd60e0e7ba70e18c.
4. LANES=16, in_state=128'h01_53_ff_00 followed by zeros -> 1-cycle latency; bytes 0..3 = 7c, ed, 16, 63, rest 63. Hold out_ready=0 for 5 cycles -> out_valid and out_state stable throughout.
5. flush asserted on the 2nd RUN cycle (LANES=4) -> next cycle IDLE, out_valid never asserts. A new block accepted afterwards produces the correct result.
6. Random sweep of 1000 blocks at each LANES value with random out_ready/in_valid stalls -> every output, passed through an inverse S-box, equals its input block; no block lost or duplicated; in_ready is never high while busy.
